// File: rtl/johnson_ring_ctr.sv
// Johnson (twisted-ring) or one-hot ring counter with enable, direction, checked load,
// binary phase decode, terminal-count strobe and optional recovery from illegal states.
module johnson_ring_ctr #(
  parameter int unsigned N            = 4,
  parameter int unsigned MODE         = 0,
  parameter int unsigned SELF_CORRECT = 1,
  localparam int unsigned PW          = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          en,
  input  logic          dir,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  count,
  output logic [PW-1:0] phase,
  output logic          tc,
  output logic          load_err,
  output logic          illegal
);

  localparam logic [N-1:0] One    = {{(N - 1){1'b0}}, 1'b1};
  localparam logic [N-1:0] RstVal = (MODE == 0) ? {N{1'b0}} : One;
  localparam int unsigned  Last   = (MODE == 0) ? (2 * N - 1) : (N - 1);

  typedef struct packed {
    logic          ok;
    logic [PW-1:0] ph;
  } dec_t;

  // Maps a counter value to its phase; ok=0 (and ph=0) for any value outside the sequence.
  function automatic dec_t decode(input logic [N-1:0] v);
    dec_t          r;
    logic [N-1:0]  m;
    r = '0;
    if (MODE == 0) begin
      for (int k = 0; k <= int'(N); k++) begin
        m = (One << k) - One;
        if (v == m) begin
          r.ok = 1'b1;
          r.ph = PW'(k);
        end
        if (k > 0 && k < int'(N) && v == ~m) begin
          r.ok = 1'b1;
          r.ph = PW'(int'(N) + k);
        end
      end
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        if (v == (One << k)) begin
          r.ok = 1'b1;
          r.ph = PW'(k);
        end
      end
    end
    return r;
  endfunction

  logic [N-1:0] count_q, count_d;
  logic         load_err_q, load_err_d;
  logic [N-1:0] shift_up, shift_dn;
  dec_t         cur_dec, ld_dec;

  always_comb begin
    cur_dec = decode(count_q);
    ld_dec  = decode(load_val);
  end

  always_comb begin
    if (MODE == 0) begin
      shift_up = {count_q[N-2:0], ~count_q[N-1]};
      shift_dn = {~count_q[0], count_q[N-1:1]};
    end else begin
      shift_up = {count_q[N-2:0], count_q[N-1]};
      shift_dn = {count_q[0], count_q[N-1:1]};
    end
  end

  always_comb begin
    count_d    = count_q;
    load_err_d = load & ~ld_dec.ok;
    if (SELF_CORRECT != 0 && !cur_dec.ok) begin
      count_d = RstVal;
    end else if (load && ld_dec.ok) begin
      count_d = load_val;
    end else if (en) begin
      count_d = dir ? shift_up : shift_dn;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count_q    <= RstVal;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  // An illegal value has no position in the sequence, so it is never terminal.
  always_comb begin
    count    = count_q;
    load_err = load_err_q;
    illegal  = ~cur_dec.ok;
    phase    = cur_dec.ph;
    tc       = en & ~load & cur_dec.ok &
               (dir ? (cur_dec.ph == PW'(Last)) : (cur_dec.ph == '0));
  end

endmodule
